// File: rtl/alu_sequencer.sv
// alu_sequencer
// Operator-facing control FSM for the 8-bit switch/button ALU demonstrator.
// Captures operand A, operand B and an opcode from the switches and buttons,
// holds the ALU inputs stable for a settle window, then registers the ALU
// result and flags and chooses what the seven-segment display shows.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   sw_data               live switch word
//   enter_p, back_p       confirm / undo pulses (one cycle wide)
//   op_next_p, op_prev_p  opcode step pulses
//   alu_result, alu_flags combinational ALU output and {N,Z,C,V}
//   alu_a, alu_b, alu_op  registered ALU inputs
//   result, flags         captured ALU output
//   disp_value            value routed to the seven-segment driver
//   stage                 current state code, for the LEDs
//   busy                  high while the ALU is settling
//
// Configuration macro: ALU_CHAIN_EN
//   defined   - enter in SHOW loads the result into A and goes to LOAD_B
//   undefined - enter in SHOW clears result/flags and goes to LOAD_A
module alu_sequencer #(
  parameter int WIDTH       = 8,
  parameter int NUM_OPS     = 5,
  parameter int CALC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             enter_p,
  input  logic             back_p,
  input  logic             op_next_p,
  input  logic             op_prev_p,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] disp_value,
  output logic [2:0]       stage,
  output logic             busy
);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    SEL_OP = 3'd2,
    CALC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
  localparam logic [2:0]    OP_MAX    = 3'(NUM_OPS - 1);
  localparam logic [CW-1:0] CNT_START = CW'(CALC_CYCLES - 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] a_next, b_next, result_next, disp_next;
  logic [2:0]       op_next;
  logic [3:0]       flags_next;

  // State and every output are registered so the display and LEDs only
  // change on a clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD_A;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      result     <= '0;
      flags      <= '0;
      disp_value <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      alu_a      <= a_next;
      alu_b      <= b_next;
      alu_op     <= op_next;
      result     <= result_next;
      flags      <= flags_next;
      disp_value <= disp_next;
      busy       <= (state_next == CALC);
    end
  end

  assign stage = state;

  // Next-state and next-register values. The if/else chains give the
  // pulse priority enter > back > next > prev; only the winner acts.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    a_next      = alu_a;
    b_next      = alu_b;
    op_next     = alu_op;
    result_next = result;
    flags_next  = flags;

    unique case (state)
      LOAD_A: begin
        if (enter_p) begin
          a_next     = sw_data;
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (enter_p) begin
          b_next     = sw_data;
          state_next = SEL_OP;
        end else if (back_p) begin
          state_next = LOAD_A;
        end
      end
      SEL_OP: begin
        if (enter_p) begin
          cnt_next   = CNT_START;
          state_next = CALC;
        end else if (back_p) begin
          state_next = LOAD_B;
        end else if (op_next_p) begin
          op_next = (alu_op == OP_MAX) ? 3'd0 : alu_op + 3'd1;
        end else if (op_prev_p) begin
          op_next = (alu_op == 3'd0) ? OP_MAX : alu_op - 3'd1;
        end
      end
      CALC: begin
        // Inputs are frozen here; the capture happens on the last
        // cycle of the settle window.
        if (cnt == '0) begin
          result_next = alu_result;
          flags_next  = alu_flags;
          state_next  = SHOW;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      SHOW: begin
        if (enter_p) begin
`ifdef ALU_CHAIN_EN
          a_next     = result;
          state_next = LOAD_B;
`else
          result_next = '0;
          flags_next  = '0;
          state_next  = LOAD_A;
`endif
        end else if (back_p) begin
          state_next = SEL_OP;
        end
      end
      default: begin
        state_next = LOAD_A;
      end
    endcase
  end

  // Display source follows the state being entered so it lines up with
  // the registered stage output.
  always_comb begin
    disp_next = '0;
    unique case (state_next)
      LOAD_A, LOAD_B: disp_next = sw_data;
      SEL_OP:         disp_next = WIDTH'(op_next);
      CALC:           disp_next = a_next;
      SHOW:           disp_next = result_next;
      default:        disp_next = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed operator sequences followed by
// randomized button/switch traffic, scored against a behavioural model.
module tb_alu_sequencer;

  localparam int WIDTH       = 8;
  localparam int NUM_OPS     = 5;
  localparam int CALC_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw_data;
  logic       enter_p, back_p, op_next_p, op_prev_p;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic [7:0] alu_a, alu_b, result, disp_value;
  logic [2:0] alu_op, stage;
  logic [3:0] flags;
  logic       busy;

  alu_sequencer #(
    .WIDTH(WIDTH),
    .NUM_OPS(NUM_OPS),
    .CALC_CYCLES(CALC_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_data(sw_data),
    .enter_p(enter_p),
    .back_p(back_p),
    .op_next_p(op_next_p),
    .op_prev_p(op_prev_p),
    .alu_result(alu_result),
    .alu_flags(alu_flags),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .result(result),
    .flags(flags),
    .disp_value(disp_value),
    .stage(stage),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic [3:0] fl;
    logic [7:0] disp;
    logic [2:0] stage;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the operator flow: which step we are on,
  // the values held, and how many settle cycles remain.
  int         m_step;
  logic [7:0] m_a, m_b, m_res;
  logic [2:0] m_op;
  logic [3:0] m_fl;
  int         m_left;
  bit         rand_alu = 0;

  // Reference ALU driven onto alu_result: add, sub, and, or, xor.
  function automatic void alu_fn(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op,
                                 output logic [7:0] r, output logic [3:0] f);
    logic [8:0] wide;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[7:0];
        c = wide[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[7:0];
        c = wide[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      default: r = a ^ b;
    endcase
    f = {r[7], (r == 8'h00), c, v};
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input logic r, input logic [7:0] sw,
                           input logic en, input logic bk,
                           input logic nx, input logic pv,
                           input logic [7:0] ar, input logic [3:0] af);
    if (r) begin
      m_step = 0;
      m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_fl = 0; m_left = 0;
      return;
    end
    case (m_step)
      0: if (en) begin m_a = sw; m_step = 1; end
      1: begin
        if (en) begin m_b = sw; m_step = 2; end
        else if (bk) m_step = 0;
      end
      2: begin
        if (en) begin m_left = CALC_CYCLES; m_step = 3; end
        else if (bk) m_step = 1;
        else if (nx) m_op = 3'((int'(m_op) + 1) % NUM_OPS);
        else if (pv) m_op = 3'((int'(m_op) + NUM_OPS - 1) % NUM_OPS);
      end
      3: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_res = ar;
          m_fl = af;
          m_step = 4;
        end
      end
      default: begin
        if (en) begin
`ifdef ALU_CHAIN_EN
          m_a = m_res;
          m_step = 1;
`else
          m_res = 0;
          m_fl = 0;
          m_step = 0;
`endif
        end else if (bk) m_step = 2;
      end
    endcase
  endtask

  // Drive one cycle of inputs, step the model and queue the expected outputs.
  task automatic applyStimulus(input logic r, input logic [7:0] sw,
                               input logic en, input logic bk,
                               input logic nx, input logic pv);
    exp_t e;
    logic [7:0] ar;
    logic [3:0] af;
    @(negedge clk);
    alu_fn(m_a, m_b, m_op, ar, af);
    if (rand_alu) begin
      ar = 8'($urandom);
      af = 4'($urandom);
    end
    reset = r; sw_data = sw;
    enter_p = en; back_p = bk; op_next_p = nx; op_prev_p = pv;
    alu_result = ar; alu_flags = af;
    modelStep(r, sw, en, bk, nx, pv, ar, af);
    e.a = m_a; e.b = m_b; e.op = m_op; e.res = m_res; e.fl = m_fl;
    e.stage = 3'(m_step);
    e.busy = (m_step == 3);
    case (m_step)
      0, 1:    e.disp = r ? 8'h00 : sw;
      2:       e.disp = {5'b0, m_op};
      3:       e.disp = m_a;
      default: e.disp = m_res;
    endcase
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, sw_data, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%02h required=0x%02h at %0t",
               name, act, req, $time);
    end
  endtask

  // Monitor: each cycle the DUT presents a fresh registered output set,
  // which is compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("stage", {5'b0, stage}, {5'b0, e.stage});
        checkOutput("alu_a", alu_a, e.a);
        checkOutput("alu_b", alu_b, e.b);
        checkOutput("alu_op", {5'b0, alu_op}, {5'b0, e.op});
        checkOutput("result", result, e.res);
        checkOutput("flags", {4'b0, flags}, {4'b0, e.fl});
        checkOutput("disp_value", disp_value, e.disp);
        checkOutput("busy", {7'b0, busy}, {7'b0, e.busy});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1; sw_data = 0; enter_p = 0; back_p = 0;
    op_next_p = 0; op_prev_p = 0; alu_result = 0; alu_flags = 0;
    m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_fl = 0; m_left = 0;

    $display("[TB] reset and operand capture");
    applyStimulus(1, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 8'h00, 1, 1, 1, 1);
    applyStimulus(0, 8'h12, 1, 0, 0, 0);
    applyStimulus(0, 8'h34, 1, 0, 0, 0);

    $display("[TB] opcode wraparound");
    applyStimulus(0, 8'h34, 0, 0, 0, 1);
    applyStimulus(0, 8'h34, 0, 0, 1, 0);
    applyStimulus(0, 8'h34, 0, 0, 0, 1);
    applyStimulus(0, 8'h34, 0, 0, 1, 0);

    $display("[TB] calculation 0x12+0x34");
    applyStimulus(0, 8'h34, 1, 0, 0, 0);
    applyStimulus(0, 8'h34, 1, 1, 1, 1);
    idle(2);

    $display("[TB] enter in SHOW");
    applyStimulus(0, 8'h34, 1, 0, 0, 0);
    if (m_step == 0) applyStimulus(0, 8'h55, 1, 0, 0, 0);

    $display("[TB] enter and back together in LOAD_B");
    applyStimulus(0, 8'h66, 1, 1, 0, 0);

    $display("[TB] reset during CALC");
    applyStimulus(0, 8'h66, 1, 0, 0, 0);
    applyStimulus(0, 8'h66, 0, 0, 0, 0);
    applyStimulus(1, 8'h66, 1, 0, 0, 0);
    idle(1);

    $display("[TB] back from SHOW");
    applyStimulus(0, 8'h81, 1, 0, 0, 0);
    applyStimulus(0, 8'h7f, 1, 0, 0, 0);
    applyStimulus(0, 8'h7f, 0, 0, 1, 0);
    applyStimulus(0, 8'h7f, 1, 0, 0, 0);
    idle(3);
    applyStimulus(0, 8'h7f, 0, 1, 0, 0);
    applyStimulus(0, 8'h7f, 0, 0, 1, 0);
    applyStimulus(0, 8'h7f, 1, 0, 0, 0);
    idle(3);

    $display("[TB] randomized traffic");
    rand_alu = 1;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0), 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(2);

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d required=0 pending expectations",
               exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operator-facing control FSM for the 8-bit switch/button ALU demonstrator. It takes debounced one-cycle button pulses and the live switch word, captures operands A and B and an opcode in sequence, and holds the ALU inputs stable. After a settle window it registers the ALU result and flags, and selects what the seven-segment display shows. It sits between the button debouncers and the ALU/display datapath.

## Interface
Parameters:
- WIDTH, 8: operand, result and switch width.
- NUM_OPS, 5: number of valid opcodes (0..NUM_OPS-1), at most 8.
- CALC_CYCLES, 2: clocks the ALU inputs are held before the result is captured, at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sw_data  in  WIDTH  live switch value.
- enter_p  in  1  confirm pulse (BTNU), one cycle wide.
- back_p  in  1  undo pulse (BTND), one cycle wide.
- op_next_p  in  1  next-opcode pulse (BTNR).
- op_prev_p  in  1  previous-opcode pulse (BTNL).
- alu_result  in  WIDTH  combinational ALU output.
- alu_flags  in  4  {N,Z,C,V} from the ALU.
- alu_a  out  WIDTH  registered operand A.
- alu_b  out  WIDTH  registered operand B.
- alu_op  out  3  registered opcode.
- result  out  WIDTH  captured result.
- flags  out  4  captured flags.
- disp_value  out  WIDTH  value routed to the 7-seg driver.
- stage  out  3  one-hot-free encoding of the current state, for the LEDs.
- busy  out  1  high while in CALC.

## Operation
- States: LOAD_A(0), LOAD_B(1), SEL_OP(2), CALC(3), SHOW(4). `stage` equals the state code.
- Event priority when pulses coincide: enter_p > back_p > op_next_p > op_prev_p. Only the highest-priority pulse is acted on.
- LOAD_A:
  - enter_p: alu_a <= sw_data, go to LOAD_B.
  - back_p: no effect.
- LOAD_B:
  - enter_p: alu_b <= sw_data, go to SEL_OP.
  - back_p: go to LOAD_A. alu_a is retained.
- SEL_OP:
  - op_next_p: alu_op <= (alu_op==NUM_OPS-1) ? 0 : alu_op+1.
  - op_prev_p: alu_op <= (alu_op==0) ? NUM_OPS-1 : alu_op-1.
  - enter_p: load the settle counter with CALC_CYCLES-1, go to CALC.
  - back_p: go to LOAD_B.
- CALC:
  - All pulses are ignored.
  - The counter decrements each cycle. In the cycle the counter is 0: result <= alu_result, flags <= alu_flags, go to SHOW.
- SHOW:
  - enter_p: start a new operation (see Configuration).
  - back_p: go to SEL_OP with operands and opcode kept, so the operator can pick another op.
  - op pulses: ignored.
- disp_value:
  - sw_data (live) in LOAD_A/LOAD_B.
  - alu_op zero-extended in SEL_OP.
  - alu_a in CALC.
  - result in SHOW.
- alu_a, alu_b and alu_op change only on the transitions listed above. They never change during CALC.

## Timing
- Reset values: state LOAD_A, alu_a=0, alu_b=0, alu_op=0, result=0, flags=0, busy=0, disp_value=0. Reset overrides every pulse in the same cycle.
- All outputs are registered. Each takes effect on the clock edge after the pulse.
- Latency from enter_p in SEL_OP to the SHOW state is CALC_CYCLES+1 clocks. busy is high exactly CALC_CYCLES cycles.
- Reset asserted mid-CALC aborts the operation. result and flags return to 0.
- A pulse held high for several cycles is treated as repeated events. Debouncers upstream guarantee single-cycle pulses.

## Configuration
- ALU_CHAIN_EN defined:
  - enter_p in SHOW performs alu_a <= result and goes to LOAD_B (accumulator chaining).
  - flags stay valid until the next capture.
- ALU_CHAIN_EN undefined:
  - enter_p in SHOW goes to LOAD_A.
  - alu_a, alu_b and alu_op are retained. result and flags are cleared to 0.

## Test plan
- Reset, then sw_data=0x12 with enter_p, sw_data=0x34 with enter_p. Expect alu_a=0x12, alu_b=0x34, stage=2.
- In SEL_OP with alu_op=4 and NUM_OPS=5: op_next_p gives alu_op=0. op_prev_p then gives alu_op=4.
- In SEL_OP, enter_p with CALC_CYCLES=2 and alu_result=0x46, flags=4'b0000. Expect busy high for exactly 2 cycles, then result=0x46, disp_value=0x46, stage=4.
- enter_p and back_p in the same cycle in LOAD_B. Expect enter wins: alu_b captured, stage=2.
- Reset pulse during CALC. Expect the next cycle stage=0 and result=0.
- In SHOW with result=0x46, enter_p:
  - ALU_CHAIN_EN: alu_a=0x46 and stage=1.
  - Without it: stage=0 and result=0.
